// File: rtl/button_pkg.sv
// Shared constants for the button debounce slice.
package button_pkg;

    localparam int unsigned N_BTN_DEF    = 5;
    localparam int unsigned DEBOUNCE_DEF = 1000000;
    localparam int unsigned DEBOUNCE_SIM = 4;

endpackage : button_pkg

// File: rtl/button_debounce_if.sv
// Button bundle between pad side and debouncer; BTN_LATCH_EN adds the sticky latch signals.
interface button_debounce_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
`ifdef BTN_LATCH_EN
    logic [N_BTN-1:0] btn_clr;
    logic [N_BTN-1:0] btn_latched;

    modport master (
        output btn_raw,
        output btn_clr,
        input  btn_stable,
        input  btn_press,
        input  btn_release,
        input  btn_latched
    );

    modport slave (
        input  btn_raw,
        input  btn_clr,
        output btn_stable,
        output btn_press,
        output btn_release,
        output btn_latched
    );
`else
    modport master (
        output btn_raw,
        input  btn_stable,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_stable,
        output btn_press,
        output btn_release
    );
`endif
endinterface : button_debounce_if

// File: rtl/btn_debounce_cell.sv
// One button channel: 2-flop synchronizer, debounce counter, stable level, edge pulses.
// With BTN_LATCH_EN a sticky "pressed since clear" flag is added.
module btn_debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
`ifdef BTN_LATCH_EN
    input  logic clr,
    output logic latched,
`endif
    output logic stable,
    output logic press_pulse,
    output logic release_pulse
);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;
    logic             accept_c;

    assign accept_c = (sync1 != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    // Any cycle agreeing with the stable level restarts the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt           <= '0;
            stable        <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (accept_c) begin
                cnt           <= '0;
                stable        <= sync1;
                press_pulse   <= sync1;
                release_pulse <= ~sync1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef BTN_LATCH_EN
    // Set on an accepted press; set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            latched <= 1'b0;
        end else if (accept_c && sync1) begin
            latched <= 1'b1;
        end else if (clr) begin
            latched <= 1'b0;
        end
    end
`endif

endmodule : btn_debounce_cell

// File: rtl/button_debounce.sv
// Debounces N_BTN raw pushbutton pads into stable levels and press/release pulses.
// Optional macro BTN_LATCH_EN adds per-channel sticky press latches with clear.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    button_debounce_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [N_BTN-1:0] stable_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] release_v;
`ifdef BTN_LATCH_EN
    logic [N_BTN-1:0] latched_v;
`endif

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        btn_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .raw          (bus.btn_raw[i]),
`ifdef BTN_LATCH_EN
            .clr          (bus.btn_clr[i]),
            .latched      (latched_v[i]),
`endif
            .stable       (stable_v[i]),
            .press_pulse  (press_v[i]),
            .release_pulse(release_v[i])
        );
    end

    assign bus.btn_stable  = stable_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
`ifdef BTN_LATCH_EN
    assign bus.btn_latched = latched_v;
`endif

endmodule : button_debounce
